// File: rtl/edge_pkg.sv
// rtl/edge_pkg.sv - shared state type, pixel width and latency default for edge_stream_ctrl
package edge_pkg;

  localparam int PIXEL_W = 8;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;

  // Pixel-in to result advances of the 3x3 filter: two line buffers plus pipeline.
  function automatic int edge_latency(input int width);
    return 2 * width + 13;
  endfunction

endpackage

// File: rtl/edge_pos_counter.sv
// rtl/edge_pos_counter.sv - x/y position of accepted results with frame markers
// BORDER_ZERO_EN: when defined, border flags results whose window overlaps a line wrap or previous frame.
module edge_pos_counter #(
  parameter int WIDTH  = 1000,
  parameter int HEIGHT = 750
) (
  input  logic Clk,
  input  logic nReset,
  input  logic clr,
  input  logic adv,
  output logic sof,
  output logic eol,
  output logic last,
  output logic border
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic          x_last;
  logic          y_last;

  assign x_last = (out_x == X_LAST);
  assign y_last = (out_y == Y_LAST);

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      out_x <= '0;
      out_y <= '0;
    end else if (clr) begin
      out_x <= '0;
      out_y <= '0;
    end else if (adv) begin
      if (x_last) begin
        out_x <= '0;
        out_y <= y_last ? '0 : out_y + 1'b1;
      end else begin
        out_x <= out_x + 1'b1;
      end
    end
  end

  assign sof  = (out_x == '0) && (out_y == '0);
  assign eol  = x_last;
  assign last = x_last && y_last;

`ifdef BORDER_ZERO_EN
  assign border = (out_x < XW'(2)) || (out_y < YW'(2));
`else
  assign border = 1'b0;
`endif

endmodule

// File: rtl/edge_stream_ctrl.sv
// rtl/edge_stream_ctrl.sv - frame sequencer for the 3x3 edge filter: feed, zero-flush, drain with backpressure
// BORDER_ZERO_EN: when defined, results with x<2 or y<2 are forced to zero.
module edge_stream_ctrl
  import edge_pkg::*;
#(
  parameter int WIDTH   = 1000,
  parameter int HEIGHT  = 750,
  parameter int LATENCY = edge_latency(WIDTH)
) (
  input  logic               Clk,
  input  logic               nReset,
  input  logic               start,
  input  logic               abort,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIXEL_W-1:0] in_pixel,
  output logic               filt_en,
  output logic [PIXEL_W-1:0] filt_pixel_in,
  input  logic [PIXEL_W-1:0] filt_pixel_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PIXEL_W-1:0] out_pixel,
  output logic               out_sof,
  output logic               out_eol,
  output logic               busy,
  output logic               frame_done
);

  localparam int N  = WIDTH * HEIGHT;
  localparam int IW = $clog2(N + 1);
  localparam int FW = $clog2(LATENCY + 1);
  localparam int AW = $clog2(N + LATENCY + 1);

  localparam logic [IW-1:0] N_CNT  = IW'(N);
  localparam logic [IW-1:0] N_LAST = IW'(N - 1);
  localparam logic [FW-1:0] F_LAST = FW'(LATENCY - 1);
  localparam logic [AW-1:0] LAT_A  = AW'(LATENCY);

  state_t        state;
  state_t        state_nx;
  logic [IW-1:0] in_cnt;
  logic [FW-1:0] flush_cnt;
  logic [AW-1:0] adv_cnt;
  logic          slot_free;
  logic          accept;
  logic          frame_start;
  logic          pos_sof;
  logic          pos_eol;
  logic          pos_last;
  logic          pos_border;

  assign slot_free   = !out_valid || out_ready;
  assign accept      = out_valid && out_ready;
  assign frame_start = (state == IDLE) && start && !abort;

  // Phase changes are taken on the edge of the final advance of each phase, so the
  // only result still pending on entry to DRAIN is the last one.
  always_comb begin
    state_nx      = state;
    in_ready      = 1'b0;
    filt_en       = 1'b0;
    filt_pixel_in = '0;
    frame_done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = RUN;
      end
      RUN: begin
        in_ready      = slot_free && (in_cnt < N_CNT);
        filt_en       = in_valid && in_ready;
        filt_pixel_in = in_pixel;
        if (filt_en && (in_cnt == N_LAST)) state_nx = FLUSH;
      end
      FLUSH: begin
        filt_en = slot_free;
        if (filt_en && (flush_cnt == F_LAST)) state_nx = DRAIN;
      end
      DRAIN: begin
        if (accept && pos_last) begin
          frame_done = 1'b1;
          state_nx   = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (abort) begin
      state_nx   = IDLE;
      in_ready   = 1'b0;
      filt_en    = 1'b0;
      frame_done = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      in_cnt    <= '0;
      flush_cnt <= '0;
      adv_cnt   <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nx;
      if (abort || frame_start) begin
        in_cnt    <= '0;
        flush_cnt <= '0;
        adv_cnt   <= '0;
        out_valid <= 1'b0;
      end else begin
        if (filt_en) adv_cnt <= adv_cnt + 1'b1;
        if (filt_en && (state == RUN)) in_cnt <= in_cnt + 1'b1;
        if (filt_en && (state == FLUSH)) flush_cnt <= flush_cnt + 1'b1;
        // The filter output becomes meaningful once its pipeline has been filled.
        if (filt_en && (adv_cnt >= LAT_A)) out_valid <= 1'b1;
        else if (out_ready) out_valid <= 1'b0;
      end
    end
  end

  edge_pos_counter #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT)
  ) u_pos (
    .Clk   (Clk),
    .nReset(nReset),
    .clr   (abort || frame_start),
    .adv   (accept),
    .sof   (pos_sof),
    .eol   (pos_eol),
    .last  (pos_last),
    .border(pos_border)
  );

  assign out_pixel = (out_valid && !pos_border) ? filt_pixel_out : '0;
  assign out_sof   = out_valid && pos_sof;
  assign out_eol   = out_valid && pos_eol;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_edge_stream_ctrl.sv
// tb/tb_edge_stream_ctrl.sv - directed/random frames against a 1-D gradient filter stub and result model
module tb_edge_stream_ctrl;

  localparam int W = 4;
  localparam int H = 3;
  localparam int L = 21;
  localparam int N = W * H;

  logic       Clk;
  logic       nReset;
  logic       start;
  logic       abort;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_pixel;
  logic       filt_en;
  logic [7:0] filt_pixel_in;
  logic [7:0] filt_pixel_out;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_pixel;
  logic       out_sof;
  logic       out_eol;
  logic       busy;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  edge_stream_ctrl #(
    .WIDTH  (W),
    .HEIGHT (H),
    .LATENCY(L)
  ) dut (
    .Clk           (Clk),
    .nReset        (nReset),
    .start         (start),
    .abort         (abort),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_pixel      (in_pixel),
    .filt_en       (filt_en),
    .filt_pixel_in (filt_pixel_in),
    .filt_pixel_out(filt_pixel_out),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pixel     (out_pixel),
    .out_sof       (out_sof),
    .out_eol       (out_eol),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic logic [7:0] absd(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Filter stub: result after an advance is |p(a-L) - p(a-L-1)|, held between advances.
  logic [7:0] dl [0:L+1];
  always @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i <= L + 1; i++) dl[i] <= 8'h00;
    end else if (filt_en) begin
      dl[0] <= filt_pixel_in;
      for (int i = 1; i <= L + 1; i++) dl[i] <= dl[i-1];
    end
  end
  assign filt_pixel_out = absd(dl[L], dl[L+1]);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_result(input logic [7:0] pix [N], input int k);
    logic [7:0] prev;
    prev = (k > 0) ? pix[k-1] : 8'h00;
`ifdef BORDER_ZERO_EN
    if ((k % W) < 2 || (k / W) < 2) return 8'h00;
`endif
    return absd(pix[k], prev);
  endfunction

  // mode 0: always valid/ready; 1: random valid/ready; 2: ready except a 5-cycle stall.
  task automatic run_frame(input int mode, input int abort_at_flush, input bit restart_mid, input bit const80);
    logic [7:0] pix [N];
    logic [7:0] prev_out;
    int in_idx, res_k, adv, flush_adv, cyc, last_in_cyc, stall_left;
    bit done, aborted, seen_valid, stall_used, stalled_prev, restart_done, hs, acc;
    for (int i = 0; i < N; i++) pix[i] = const80 ? 8'h80 : 8'($urandom);
    in_idx = 0; res_k = 0; adv = 0; flush_adv = 0; cyc = 0; last_in_cyc = 0; stall_left = 0;
    done = 0; aborted = 0; seen_valid = 0; stall_used = 0; stalled_prev = 0; restart_done = 0;
    prev_out = 8'h00;
    while (!done && cyc < 600) begin
      @(negedge Clk);
      start = (cyc == 0);
      if (restart_mid && !restart_done && in_idx == 5) begin
        start = 1'b1;
        restart_done = 1;
      end
      abort    = (abort_at_flush > 0) && (flush_adv == abort_at_flush);
      in_valid = (cyc > 0) && ((mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1);
      in_pixel = (in_idx < N) ? pix[in_idx] : 8'($urandom);
      if (mode == 2 && out_valid && !stall_used && res_k == 3) begin
        stall_left = 5;
        stall_used = 1;
      end
      out_ready = (stall_left > 0) ? 1'b0 : ((mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1);
      if (stall_left > 0) stall_left--;
      #1;
      hs  = in_valid && in_ready;
      acc = out_valid && out_ready;
      if (hs) begin
        chk("in_within_n", in_idx < N, 1);
        chk("in_hs_en", filt_en, 1);
        chk("in_hs_pixel", filt_pixel_in, (in_idx < N) ? pix[in_idx] : 8'h00);
        in_idx++;
        last_in_cyc = cyc;
      end
      if (in_ready && in_idx >= N && !hs) chk("in_ready_after_n", in_ready, 0);
      if (filt_en && !hs) begin
        chk("flush_after_input", in_idx, N);
        chk("flush_zero", filt_pixel_in, 8'h00);
        flush_adv++;
      end
      if (out_valid && !out_ready) begin
        chk("stall_no_advance", {filt_en, in_ready}, 2'b00);
        if (stalled_prev) chk("stall_hold", out_pixel, prev_out);
      end
      if (out_valid && !seen_valid) begin
        chk("first_valid_adv", adv, L + 1);
        seen_valid = 1;
      end
      if (acc) begin
        if (res_k < N) begin
          chk("out_pixel", out_pixel, exp_result(pix, res_k));
          chk("out_sof", out_sof, res_k == 0);
          chk("out_eol", out_eol, (res_k % W) == W - 1);
          chk("frame_done_at_last", frame_done, res_k == N - 1);
        end else begin
          chk("extra_result", res_k, N - 1);
        end
        res_k++;
        if (frame_done) done = 1;
      end else if (frame_done) begin
        chk("spurious_done", frame_done, 0);
      end
      if (abort) begin
        chk("abort_no_done", frame_done, 0);
        aborted = 1;
        done = 1;
      end
      if (filt_en) adv++;
      prev_out     = out_pixel;
      stalled_prev = out_valid && !out_ready;
      cyc++;
    end
    chk("frame_timeout", done, 1);
    @(negedge Clk);
    start = 1'b0;
    abort = 1'b0;
    #1;
    chk("idle_after_busy", busy, 0);
    chk("idle_after_valid", out_valid, 0);
    chk("idle_after_done", frame_done, 0);
    if (!aborted) begin
      chk("n_inputs", in_idx, N);
      chk("n_results", res_k, N);
      chk("n_advances", adv, N + L);
      chk("n_flush", flush_adv, L);
      if (mode == 0) chk("input_cycles", last_in_cyc, N);
      if (mode == 2) chk("stall_exercised", stall_used, 1);
    end else begin
      chk("abort_partial", res_k < N, 1);
    end
  endtask

  initial begin
    nReset = 1'b0; start = 1'b0; abort = 1'b0;
    in_valid = 1'b0; in_pixel = 8'h00; out_ready = 1'b0;
    repeat (2) @(negedge Clk);
    #1;
    chk("por_outputs", {in_ready, filt_en, filt_pixel_in, out_valid, out_pixel, out_sof, out_eol, frame_done}, 0);
    chk("por_busy", busy, 0);
    @(negedge Clk);
    nReset = 1'b1;

    // Reset in the middle of RUN
    @(negedge Clk);
    start = 1'b1; out_ready = 1'b1;
    @(negedge Clk);
    start = 1'b0; in_valid = 1'b1; in_pixel = 8'h5A;
    repeat (4) @(negedge Clk);
    #1;
    chk("mid_run_busy", busy, 1);
    nReset = 1'b0;
    #1;
    chk("rst_outputs", {in_ready, filt_en, filt_pixel_in, out_valid, out_pixel, out_sof, out_eol, frame_done}, 0);
    chk("rst_busy", busy, 0);
    @(negedge Clk);
    nReset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      #1;
      chk("idle_hold", {busy, in_ready, filt_en}, 3'b000);
    end
    in_valid = 1'b0;

    run_frame(0, 0, 0, 0);   // streaming frame, full rate
    run_frame(0, 0, 0, 1);   // constant 0x80 image
    run_frame(2, 0, 0, 0);   // 5-cycle downstream stall
    run_frame(0, 15, 0, 0);  // abort in FLUSH with results in flight
    run_frame(1, 0, 0, 0);   // full frame after abort, random handshakes
    run_frame(0, 0, 1, 0);   // start pulsed mid-RUN is ignored
    for (int f = 0; f < 3; f++) run_frame(1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
